// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter:
// FSM encoding, requester IDs and a grant helper.
package dmem_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // Collapse a one-hot {B,A} grant into a requester ID.
  function automatic req_id_t gnt_id(input logic [1:0] gnt);
    return gnt[1] ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester
// that did not win last time is chosen.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  req_id_t    last,
  output logic [1:0] gnt
);

  // One-hot grant, bit 0 = A, bit 1 = B.
  always_comb begin
    gnt = 2'b00;
    if (req_a && req_b) begin
      gnt = (last == REQ_A) ? 2'b10 : 2'b01;
    end else begin
      gnt = {req_b, req_a};
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto four byte-wide memory
// banks; one access every three cycles (IDLE/ISSUE/RESP).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [31:0]           A_WDATA,
  input  logic [3:0]            A_BE,
  output logic [31:0]           A_RDATA,
  output logic                  A_ACK,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [31:0]           B_WDATA,
  input  logic [3:0]            B_BE,
  output logic [31:0]           B_RDATA,
  output logic                  B_ACK,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [3:0]            WRITE_EN,
  output logic [3:0]            READ_EN,
  output logic [31:0]           DIN,
  input  logic [31:0]           DOUT
);

  state_t                state_q, state_d;
  req_id_t               owner_q, owner_d;
  req_id_t               last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_W-1:0]     a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]     b_rdata_q, b_rdata_d;
  logic [1:0]            gnt;
  logic                  issue;

  rr_arb2 u_rr (
    .req_a (A_REQ),
    .req_b (B_REQ),
    .last  (last_q),
    .gnt   (gnt)
  );

  // Next state: latch the winner in IDLE, capture read
  // data as ISSUE ends so it is visible throughout RESP.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d = ISSUE;
          owner_d = gnt_id(gnt);
          last_d  = gnt_id(gnt);
          if (gnt[1]) begin
            we_d    = B_WE;
            addr_d  = B_ADDR;
            wdata_d = B_WDATA;
            be_d    = B_BE;
          end else begin
            we_d    = A_WE;
            addr_d  = A_ADDR;
            wdata_d = A_WDATA;
            be_d    = A_BE;
          end
        end
      end
      ISSUE: begin
        state_d = RESP;
        if (!we_q) begin
          if (owner_q == REQ_A) begin
            a_rdata_d = DOUT;
          end else begin
            b_rdata_d = DOUT;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers; reset leaves B as last
  // winner so the first contention goes to A.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      owner_q   <= REQ_A;
      last_q    <= REQ_B;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Bank and requester outputs, enables only in ISSUE.
  always_comb begin
    issue    = (state_q == ISSUE);
    WRITE_EN = (issue && we_q) ? be_q : 4'b0000;
    READ_EN  = (issue && !we_q) ? 4'b1111 : 4'b0000;
    DIN      = (issue && we_q) ? wdata_q : '0;
    W_ADDR   = addr_q;
    R_ADDR   = addr_q;
    A_ACK    = (state_q == RESP) && (owner_q == REQ_A);
    B_ACK    = (state_q == RESP) && (owner_q == REQ_B);
    A_RDATA  = a_rdata_q;
    B_RDATA  = b_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a
// negedge-acting four-bank byte memory model.
module tb_dmem_arbiter;

  localparam int AW = 13;

  logic          CLK = 1'b0;
  logic          RST;
  logic          A_REQ, A_WE, B_REQ, B_WE;
  logic [AW-1:0] A_ADDR, B_ADDR;
  logic [31:0]   A_WDATA, B_WDATA;
  logic [3:0]    A_BE, B_BE;
  logic [31:0]   A_RDATA, B_RDATA;
  logic          A_ACK, B_ACK;
  logic [AW-1:0] W_ADDR, R_ADDR;
  logic [3:0]    WRITE_EN, READ_EN;
  logic [31:0]   DIN, DOUT;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [2048];
  logic        mem_init;

  dmem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR),
    .A_WDATA(A_WDATA), .A_BE(A_BE),
    .A_RDATA(A_RDATA), .A_ACK(A_ACK),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR),
    .B_WDATA(B_WDATA), .B_BE(B_BE),
    .B_RDATA(B_RDATA), .B_ACK(B_ACK),
    .W_ADDR(W_ADDR), .R_ADDR(R_ADDR),
    .WRITE_EN(WRITE_EN), .READ_EN(READ_EN),
    .DIN(DIN), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;

  // Byte banks act on the falling edge.
  always @(negedge CLK) begin
    if (mem_init) begin
      for (int w = 0; w < 2048; w++) mem[w] <= '0;
      mem[2] <= 32'h44332211;
      DOUT   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (WRITE_EN[i])
          mem[W_ADDR[AW-1:2]][8*i+:8] <= DIN[8*i+:8];
        if (READ_EN[i])
          DOUT[8*i+:8] <= mem[R_ADDR[AW-1:2]][8*i+:8];
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; mem_init = 1'b1;
    A_REQ = 0; A_WE = 0; A_ADDR = '0; A_WDATA = '0; A_BE = '0;
    B_REQ = 0; B_WE = 0; B_ADDR = '0; B_WDATA = '0; B_BE = '0;
    repeat (3) step();

    check("rst_wen", 32'(WRITE_EN), 0);
    check("rst_ren", 32'(READ_EN), 0);
    check("rst_ack", 32'({B_ACK, A_ACK}), 0);
    check("rst_din", DIN, 0);
    check("rst_addr", 32'({W_ADDR, R_ADDR}), 0);
    check("rst_rdata", A_RDATA | B_RDATA, 0);
    mem_init = 1'b0;
    RST = 1'b0;
    step();

    // Single read by A.
    A_REQ = 1; A_WE = 0; A_ADDR = 13'h008;
    step();
    check("rd_ren", 32'(READ_EN), 32'hF);
    check("rd_wen", 32'(WRITE_EN), 0);
    check("rd_raddr", 32'(R_ADDR), 32'h008);
    check("rd_ack_early", 32'(A_ACK), 0);
    step();
    check("rd_ack", 32'({B_ACK, A_ACK}), 32'b01);
    check("rd_data", A_RDATA, 32'h44332211);
    check("rd_ren_off", 32'(READ_EN), 0);
    A_REQ = 0;
    step();
    check("rd_ack_pulse", 32'(A_ACK), 0);

    // Byte-lane write by B.
    B_REQ = 1; B_WE = 1; B_ADDR = 13'h010;
    B_BE = 4'b0100; B_WDATA = 32'hAABBCCDD;
    step();
    check("wr_wen", 32'(WRITE_EN), 32'h4);
    check("wr_ren", 32'(READ_EN), 0);
    check("wr_din", DIN, 32'hAABBCCDD);
    check("wr_waddr", 32'(W_ADDR), 32'h010);
    step();
    check("wr_ack", 32'({B_ACK, A_ACK}), 32'b10);
    check("wr_wen_off", 32'(WRITE_EN), 0);
    B_REQ = 0;
    step();

    // Readback of the written word by B.
    B_REQ = 1; B_WE = 0; B_ADDR = 13'h010;
    step();
    step();
    check("rb_ack", 32'({B_ACK, A_ACK}), 32'b10);
    check("rb_data", B_RDATA, 32'h00BB0000);
    check("rb_a_hold", A_RDATA, 32'h44332211);
    B_REQ = 0;
    step();

    // Write with no byte enables by A.
    A_REQ = 1; A_WE = 1; A_ADDR = 13'h010;
    A_BE = 4'b0000; A_WDATA = 32'hFFFFFFFF;
    step();
    check("ew_wen", 32'(WRITE_EN), 0);
    check("ew_ren", 32'(READ_EN), 0);
    step();
    check("ew_ack", 32'({B_ACK, A_ACK}), 32'b01);
    A_REQ = 0;
    step();
    check("ew_mem", mem[4], 32'h00BB0000);

    // Contention from reset: A,B,A,B every 3 cycles.
    RST = 1;
    A_WE = 0; A_ADDR = 13'h008;
    B_WE = 0; B_ADDR = 13'h010;
    A_REQ = 1; B_REQ = 1;
    step();
    RST = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      check($sformatf("rr_c%0d", cyc),
            32'({B_ACK, A_ACK}),
            (cyc % 6 == 2) ? 32'b01 :
            (cyc % 6 == 5) ? 32'b10 : 32'b00);
    end
    A_REQ = 0; B_REQ = 0;
    repeat (3) step();

    // Reset in ISSUE aborts the access.
    A_REQ = 1; A_WE = 0; A_ADDR = 13'h008;
    step();
    check("ab_ren", 32'(READ_EN), 32'hF);
    #2;
    RST = 1;
    #1;
    check("ab_ren_rst", 32'(READ_EN), 0);
    check("ab_addr_rst", 32'(R_ADDR), 0);
    A_REQ = 0;
    step();
    check("ab_ack", 32'({B_ACK, A_ACK}), 0);
    step();
    check("ab_ack2", 32'({B_ACK, A_ACK}), 0);
    RST = 0;
    A_REQ = 1; B_REQ = 1;
    step();
    check("ab_rereq_ren", 32'(READ_EN), 32'hF);
    step();
    check("ab_rereq_ack", 32'({B_ACK, A_ACK}), 32'b01);
    A_REQ = 0; B_REQ = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
